mdu_controller: RTL
===================

MDU_CONTROLLER -- requirements
Module: mdu_controller

Interface
REQ-001 SHALL have parameter MULT_CYCLES, default 5: busy duration of mult/multu.
REQ-002 SHALL have parameter DIV_CYCLES, default 10: busy duration of div/divu.
REQ-003 SHALL have port clk  in  1  sole clock; all state updates on rising edge.
REQ-004 SHALL have port reset  in  1  synchronous, active-low reset (asserted when 0).
REQ-005 SHALL have port E_md_start  in  1  E-stage instruction issues an MDU operation this cycle.
REQ-006 SHALL have port E_md_op  in  3  operation code (encodings from shared package): NONE, MULT, MULTU, DIV, DIVU, MTHI, MTLO.
REQ-007 SHALL have port E_rs_val  in  32  forwarded rs operand.
REQ-008 SHALL have port E_rt_val  in  32  forwarded rt operand.
REQ-009 SHALL have port D_md_use  in  1  D-stage instruction is mult/div/mthi/mtlo/mfhi/mflo.
REQ-010 SHALL have port busy  out  1  long operation in progress.
REQ-011 SHALL have port hi  out  32  architectural HI.
REQ-012 SHALL have port lo  out  32  architectural LO.
REQ-013 SHALL have port md_stall  out  1  stall request ORed into the pipeline stall.

Function
REQ-014 SHALL implement states IDLE, MULT, DIV; busy = (state != IDLE).
REQ-015 SHALL, in IDLE with E_md_start=1 and op MULT/MULTU, compute the 64-bit product (signed/unsigned) into pending registers, load counter with MULT_CYCLES-1, and enter MULT.
REQ-016 SHALL, in IDLE with E_md_start=1 and op DIV/DIVU, compute quotient->pending LO and remainder->pending HI, load counter with DIV_CYCLES-1, and enter DIV.
REQ-017 SHALL decrement the counter each cycle in MULT/DIV; when the counter is 0, commit pending to hi/lo and return to IDLE on that edge.
REQ-018 SHALL satisfy: start sampled at edge t -> busy=1 in exactly the N cycles following t -> new hi/lo visible from the cycle after busy falls.
REQ-019 SHALL, in IDLE with MTHI/MTLO, write E_rs_val to hi/lo at the next edge, with busy staying 0.
REQ-020 SHALL ignore E_md_start of any op while busy; hi/lo/pending/counter are unaffected.
REQ-021 SHALL treat signed division as truncating toward zero; the remainder takes the dividend's sign.
REQ-022 SHALL, for signed 0x80000000 / 0xFFFFFFFF, give lo=0x80000000, hi=0.
REQ-023 SHALL, for divisor 0 (DIV or DIVU), still run DIV_CYCLES of busy and leave hi/lo unchanged at commit.
REQ-024 SHALL compute md_stall combinationally as D_md_use & (busy | (E_md_start & op in {MULT, MULTU, DIV, DIVU})).
REQ-025 SHALL treat op NONE with E_md_start=1 as a no-op.

Reset
REQ-026 SHALL, with reset=0 at a rising edge, set state=IDLE, counter=0, hi=0, lo=0, pending=0, which forces busy=0; md_stall then depends only on current inputs.
REQ-027 SHALL, on reset during MULT/DIV, abort the operation with no commit.

Structure
REQ-028 SHALL define op encodings, state encodings and default cycle counts in shared package mdu_pkg; the counter width derives from max(MULT_CYCLES, DIV_CYCLES).
REQ-029 SHALL place signed/unsigned multiply and divide arithmetic in one combinational sub-module mdu_arith; mdu_controller holds the FSM, counter, pending registers and HI/LO.

Verification
REQ-030 SHALL verify: MULT 0xFFFFFFFF x 2 -> busy high 5 cycles, then hi=0xFFFFFFFF, lo=0xFFFFFFFE; MULTU same operands -> hi=1, lo=0xFFFFFFFE.
REQ-031 SHALL verify: DIV -7 / 2 -> busy 10 cycles, lo=0xFFFFFFFD, hi=0xFFFFFFFF; DIVU 7/2 -> lo=3, hi=1.
REQ-032 SHALL verify: DIV 0x80000000 / 0xFFFFFFFF -> lo=0x80000000, hi=0; DIVU x/0 with prior hi=0x11, lo=0x22 -> unchanged after 10 busy cycles.
REQ-033 SHALL verify: MULT issued, second MULT with E_md_start at busy cycle 2 -> ignored, only the first result commits; D_md_use=1 throughout -> md_stall=1 from the issue cycle until busy falls.
REQ-034 SHALL verify: MTHI 0x1234 in IDLE -> hi=0x1234 next cycle, busy stays 0; MTLO during DIV -> ignored.
REQ-035 SHALL verify: reset=0 at busy cycle 3 of DIV -> next cycle busy=0, hi=lo=0, no later commit.

Source files
------------

// File: rtl/mdu_pkg.sv
`default_nettype none
// ============================================================================
// mdu_pkg : shared op/state encodings and cycle-count defaults for the MDU
// Revision: 1.0
// ============================================================================
package mdu_pkg;

    typedef enum logic [2:0] {
        OP_NONE  = 3'd0,
        OP_MULT  = 3'd1,
        OP_MULTU = 3'd2,
        OP_DIV   = 3'd3,
        OP_DIVU  = 3'd4,
        OP_MTHI  = 3'd5,
        OP_MTLO  = 3'd6
    } md_op_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_MULT = 2'd1,
        ST_DIV  = 2'd2
    } md_state_e;

    localparam int DEF_MULT_CYCLES = 5;
    localparam int DEF_DIV_CYCLES  = 10;

    // The counter only ever holds (cycles - 1), so clog2(max) bits suffice.
    function automatic int cnt_width(input int a, input int b);
        int m;
        m = (a > b) ? a : b;
        return (m <= 2) ? 1 : $clog2(m);
    endfunction

endpackage
`default_nettype wire

// File: rtl/mdu_arith.sv
`default_nettype none
// ============================================================================
// mdu_arith : combinational signed/unsigned 32x32 multiply and divide
// Revision: 1.0
// ============================================================================
module mdu_arith (
    input  logic [31:0] i_a,
    input  logic [31:0] i_b,
    input  logic        i_signed,
    output logic [63:0] o_prod,
    output logic [31:0] o_quot,
    output logic [31:0] o_rem,
    output logic        o_div_zero
);

    logic [63:0] w_a_ext;
    logic [63:0] w_b_ext;
    logic        w_a_neg;
    logic        w_b_neg;
    logic [31:0] w_a_mag;
    logic [31:0] w_b_mag;
    logic [31:0] w_b_safe;
    logic [31:0] w_q_mag;
    logic [31:0] w_r_mag;

    always_comb begin
        w_a_ext = i_signed ? {{32{i_a[31]}}, i_a} : {32'd0, i_a};
        w_b_ext = i_signed ? {{32{i_b[31]}}, i_b} : {32'd0, i_b};
        o_prod  = w_a_ext * w_b_ext;
    end

    // Divide on magnitudes so 0x80000000 / -1 stays well defined (wraps to 0x80000000).
    always_comb begin
        w_a_neg    = i_signed & i_a[31];
        w_b_neg    = i_signed & i_b[31];
        w_a_mag    = w_a_neg ? (32'd0 - i_a) : i_a;
        w_b_mag    = w_b_neg ? (32'd0 - i_b) : i_b;
        o_div_zero = (i_b == 32'd0);
        w_b_safe   = o_div_zero ? 32'd1 : w_b_mag;
        w_q_mag    = w_a_mag / w_b_safe;
        w_r_mag    = w_a_mag % w_b_safe;
        o_quot     = (w_a_neg ^ w_b_neg) ? (32'd0 - w_q_mag) : w_q_mag;
        o_rem      = w_a_neg ? (32'd0 - w_r_mag) : w_r_mag;
    end

endmodule
`default_nettype wire

// File: rtl/mdu_controller.sv
`default_nettype none
// ============================================================================
// mdu_controller : multi-cycle HI/LO unit with busy/stall generation
// Revision: 1.0
// ============================================================================
module mdu_controller
    import mdu_pkg::*;
#(
    parameter int MULT_CYCLES = DEF_MULT_CYCLES,
    parameter int DIV_CYCLES  = DEF_DIV_CYCLES
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        E_md_start,
    input  logic [2:0]  E_md_op,
    input  logic [31:0] E_rs_val,
    input  logic [31:0] E_rt_val,
    input  logic        D_md_use,
    output logic        busy,
    output logic [31:0] hi,
    output logic [31:0] lo,
    output logic        md_stall
);

    localparam int            CW          = cnt_width(MULT_CYCLES, DIV_CYCLES);
    localparam logic [CW-1:0] C_MULT_LOAD = CW'(MULT_CYCLES - 1);
    localparam logic [CW-1:0] C_DIV_LOAD  = CW'(DIV_CYCLES - 1);

    md_state_e   r_state;
    md_state_e   w_state_nxt;
    logic [CW-1:0] r_cnt;
    logic [CW-1:0] w_cnt_nxt;
    logic [31:0] r_hi, r_lo, r_pend_hi, r_pend_lo;
    logic [31:0] w_hi_nxt, w_lo_nxt, w_pend_hi_nxt, w_pend_lo_nxt;

    logic        w_signed;
    logic        w_long_op;
    logic [63:0] w_prod;
    logic [31:0] w_quot;
    logic [31:0] w_rem;
    logic        w_div_zero;

    assign w_signed  = (E_md_op == OP_MULT) || (E_md_op == OP_DIV);
    assign w_long_op = E_md_start && ((E_md_op == OP_MULT) || (E_md_op == OP_MULTU) ||
                                      (E_md_op == OP_DIV)  || (E_md_op == OP_DIVU));

    mdu_arith u_arith (
        .i_a        (E_rs_val),
        .i_b        (E_rt_val),
        .i_signed   (w_signed),
        .o_prod     (w_prod),
        .o_quot     (w_quot),
        .o_rem      (w_rem),
        .o_div_zero (w_div_zero)
    );

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state   <= ST_IDLE;
            r_cnt     <= '0;
            r_hi      <= '0;
            r_lo      <= '0;
            r_pend_hi <= '0;
            r_pend_lo <= '0;
        end else begin
            r_state   <= w_state_nxt;
            r_cnt     <= w_cnt_nxt;
            r_hi      <= w_hi_nxt;
            r_lo      <= w_lo_nxt;
            r_pend_hi <= w_pend_hi_nxt;
            r_pend_lo <= w_pend_lo_nxt;
        end
    end

    always_comb begin
        w_state_nxt   = r_state;
        w_cnt_nxt     = r_cnt;
        w_hi_nxt      = r_hi;
        w_lo_nxt      = r_lo;
        w_pend_hi_nxt = r_pend_hi;
        w_pend_lo_nxt = r_pend_lo;
        case (r_state)
            ST_IDLE: begin
                if (E_md_start) begin
                    case (E_md_op)
                        OP_MULT, OP_MULTU: begin
                            w_pend_hi_nxt = w_prod[63:32];
                            w_pend_lo_nxt = w_prod[31:0];
                            w_cnt_nxt     = C_MULT_LOAD;
                            w_state_nxt   = ST_MULT;
                        end
                        OP_DIV, OP_DIVU: begin
                            // A zero divisor commits the current HI/LO back unchanged.
                            w_pend_hi_nxt = w_div_zero ? r_hi : w_rem;
                            w_pend_lo_nxt = w_div_zero ? r_lo : w_quot;
                            w_cnt_nxt     = C_DIV_LOAD;
                            w_state_nxt   = ST_DIV;
                        end
                        OP_MTHI: w_hi_nxt = E_rs_val;
                        OP_MTLO: w_lo_nxt = E_rs_val;
                        default: ;
                    endcase
                end
            end
            ST_MULT, ST_DIV: begin
                if (r_cnt == '0) begin
                    w_hi_nxt    = r_pend_hi;
                    w_lo_nxt    = r_pend_lo;
                    w_state_nxt = ST_IDLE;
                end else begin
                    w_cnt_nxt = r_cnt - 1'b1;
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    assign busy     = (r_state != ST_IDLE);
    assign hi       = r_hi;
    assign lo       = r_lo;
    assign md_stall = D_md_use & (busy | w_long_op);

endmodule
`default_nettype wire
